// File: rtl/ifid_stage_reg.sv
// rtl/ifid_stage_reg.sv - IF/ID stage register with one-entry skid buffer and registered field decode
// Beats are decoded on entry; a skid entry carries its decoded fields across into main.
module ifid_stage_reg #(
  parameter int              PC_W     = 16,
  parameter int              INSTR_W  = 16,
  parameter int              OP_W     = 4,
  parameter int              REG_W    = 3,
  parameter int              FUNCT_W  = 3,
  parameter int              IMM_W    = 6,
  parameter logic [OP_W-1:0] OP_RTYPE = 4'b0001,
  parameter logic [OP_W-1:0] OP_I_LO  = 4'b0010,
  parameter logic [OP_W-1:0] OP_I_HI  = 4'b0111,
  parameter int              CNT_W    = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [PC_W-1:0]         in_pc4,
  input  logic [INSTR_W-1:0]      in_instr,
  input  logic                    ifid_write,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [PC_W-1:0]         out_pc4,
  output logic [OP_W-1:0]         opcode,
  output logic [1:0]              instr_type,
  output logic [REG_W-1:0]        rs,
  output logic [REG_W-1:0]        rt,
  output logic [REG_W-1:0]        rd,
  output logic [FUNCT_W-1:0]      funct,
  output logic [IMM_W-1:0]        imm,
  output logic [INSTR_W-OP_W-1:0] jaddr,
  output logic [CNT_W-1:0]        stall_cnt
);

  localparam int RS_HI  = INSTR_W - OP_W - 1;
  localparam int RT_HI  = RS_HI - REG_W;
  localparam int RD_HI  = RT_HI - REG_W;
  localparam int FN_HI  = RD_HI - REG_W;
  localparam int IMM_HI = RT_HI - REG_W;

  typedef struct packed {
    logic [PC_W-1:0]         pc4;
    logic [OP_W-1:0]         opcode;
    logic [1:0]              itype;
    logic [REG_W-1:0]        rs;
    logic [REG_W-1:0]        rt;
    logic [REG_W-1:0]        rd;
    logic [FUNCT_W-1:0]      funct;
    logic [IMM_W-1:0]        imm;
    logic [INSTR_W-OP_W-1:0] jaddr;
  } beat_t;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_FULL,
    ST_SKID
  } state_t;

  typedef enum logic [1:0] {
    SEL_HOLD,
    SEL_IN,
    SEL_SKID
  } main_sel_t;

  function automatic beat_t decode(input logic [PC_W-1:0] pc4, input logic [INSTR_W-1:0] instr);
    beat_t           b;
    logic [OP_W-1:0] op;
    b        = '0;
    op       = instr[INSTR_W-1 -: OP_W];
    b.pc4    = pc4;
    b.opcode = op;
    if (op == OP_RTYPE) begin
      b.itype = 2'b00;
      b.rs    = instr[RS_HI -: REG_W];
      b.rt    = instr[RT_HI -: REG_W];
      b.rd    = instr[RD_HI -: REG_W];
      b.funct = instr[FN_HI -: FUNCT_W];
    end else if (op >= OP_I_LO && op <= OP_I_HI) begin
      b.itype = 2'b01;
      b.rs    = instr[RS_HI -: REG_W];
      b.rt    = instr[RT_HI -: REG_W];
      b.imm   = instr[IMM_HI -: IMM_W];
    end else begin
      b.itype = 2'b10;
      b.jaddr = instr[INSTR_W-OP_W-1:0];
    end
    return b;
  endfunction

  beat_t            r_main;
  beat_t            r_skid;
  logic             r_main_valid;
  logic             r_skid_valid;
  logic [CNT_W-1:0] r_stall_cnt;

  beat_t            w_in_beat;
  state_t           w_state;
  main_sel_t        w_main_sel;
  logic             w_skid_load;
  logic             w_main_valid_nxt;
  logic             w_skid_valid_nxt;
  logic             w_accept;
  logic             w_consume;
  logic             w_stall;

  assign w_in_beat = decode(in_pc4, in_instr);
  assign in_ready  = ~r_skid_valid & ifid_write;
  assign w_accept  = in_valid & in_ready;
  assign w_consume = r_main_valid & out_ready & ifid_write;
  assign w_stall   = (r_main_valid & ~out_ready) | ~ifid_write;

  always_comb begin
    w_state = ST_EMPTY;
    if (r_skid_valid) begin
      w_state = ST_SKID;
    end else if (r_main_valid) begin
      w_state = ST_FULL;
    end
  end

  // A frozen stage never accepts or consumes, so every state simply holds.
  always_comb begin
    w_main_sel       = SEL_HOLD;
    w_skid_load      = 1'b0;
    w_main_valid_nxt = r_main_valid;
    w_skid_valid_nxt = r_skid_valid;
    if (flush) begin
      w_main_valid_nxt = 1'b0;
      w_skid_valid_nxt = 1'b0;
    end else begin
      case (w_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_main_sel       = SEL_IN;
            w_main_valid_nxt = 1'b1;
          end
        end
        ST_FULL: begin
          if (w_accept && w_consume) begin
            w_main_sel = SEL_IN;
          end else if (w_accept) begin
            w_skid_load      = 1'b1;
            w_skid_valid_nxt = 1'b1;
          end else if (w_consume) begin
            w_main_valid_nxt = 1'b0;
          end
        end
        ST_SKID: begin
          if (w_consume) begin
            w_main_sel       = SEL_SKID;
            w_skid_valid_nxt = 1'b0;
          end
        end
        default: begin
          w_main_valid_nxt = 1'b0;
          w_skid_valid_nxt = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_main       <= '0;
      r_skid       <= '0;
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_stall_cnt  <= '0;
    end else begin
      r_main_valid <= w_main_valid_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      if (w_main_sel == SEL_IN) begin
        r_main <= w_in_beat;
      end else if (w_main_sel == SEL_SKID) begin
        r_main <= r_skid;
      end
      if (w_skid_load) begin
        r_skid <= w_in_beat;
      end
      if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

  assign out_valid  = r_main_valid;
  assign out_pc4    = r_main.pc4;
  assign opcode     = r_main.opcode;
  assign instr_type = r_main.itype;
  assign rs         = r_main.rs;
  assign rt         = r_main.rt;
  assign rd         = r_main.rd;
  assign funct      = r_main.funct;
  assign imm        = r_main.imm;
  assign jaddr      = r_main.jaddr;
  assign stall_cnt  = r_stall_cnt;

endmodule

// File: tb/tb_ifid_stage_reg.sv
// tb/tb_ifid_stage_reg.sv - self-checking bench for ifid_stage_reg against a queue-based reference model
// A second instance with a 3-bit stall counter shares the stimulus to exercise saturation.
module tb_ifid_stage_reg;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready, in_ready3;
  logic [15:0] in_pc4;
  logic [15:0] in_instr;
  logic        ifid_write;
  logic        flush;
  logic        out_valid, out_valid3;
  logic        out_ready;
  logic [15:0] out_pc4, out_pc43;
  logic [3:0]  opcode, opcode3;
  logic [1:0]  instr_type, instr_type3;
  logic [2:0]  rs, rs3, rt, rt3, rd, rd3, funct, funct3;
  logic [5:0]  imm, imm3;
  logic [11:0] jaddr, jaddr3;
  logic [15:0] stall_cnt;
  logic [2:0]  stall_cnt3;

  always #5 clock = ~clock;

  ifid_stage_reg dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc4(in_pc4), .in_instr(in_instr), .ifid_write(ifid_write), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc4(out_pc4), .opcode(opcode),
    .instr_type(instr_type), .rs(rs), .rt(rt), .rd(rd), .funct(funct), .imm(imm),
    .jaddr(jaddr), .stall_cnt(stall_cnt)
  );

  ifid_stage_reg #(.CNT_W(3)) dut3 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready3),
    .in_pc4(in_pc4), .in_instr(in_instr), .ifid_write(ifid_write), .flush(flush),
    .out_valid(out_valid3), .out_ready(out_ready), .out_pc4(out_pc43), .opcode(opcode3),
    .instr_type(instr_type3), .rs(rs3), .rt(rt3), .rd(rd3), .funct(funct3), .imm(imm3),
    .jaddr(jaddr3), .stall_cnt(stall_cnt3)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] q_pc[$];
  logic [15:0] q_in[$];
  logic [15:0] s_pc[$];
  logic [15:0] s_in[$];
  bit          gate = 1'b1;

  int e_pc, e_op, e_ty, e_rs, e_rt, e_rd, e_fn, e_imm, e_ja, e_cnt, e_cnt3;

  task automatic chk(input string tag, input logic [31:0] obs, input int expv);
    n_vec++;
    assert (obs === 32'(expv)) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic clear_fields();
    e_pc = 0; e_op = 0; e_ty = 0; e_rs = 0; e_rt = 0;
    e_rd = 0; e_fn = 0; e_imm = 0; e_ja = 0;
  endtask

  task automatic set_fields(input int pc, input int ins);
    clear_fields();
    e_pc = pc;
    e_op = ins / 4096;
    if (e_op == 1) begin
      e_ty = 0;
      e_rs = (ins / 512) % 8;
      e_rt = (ins / 64) % 8;
      e_rd = (ins / 8) % 8;
      e_fn = ins % 8;
    end else if (e_op >= 2 && e_op <= 7) begin
      e_ty = 1;
      e_rs = (ins / 512) % 8;
      e_rt = (ins / 64) % 8;
      e_imm = ins % 64;
    end else begin
      e_ty = 2;
      e_ja = ins % 4096;
    end
  endtask

  // One clock: present the source head, check outputs, advance the model.
  task automatic step();
    int n;
    bit rdy, cons, acc, stall, chg;
    in_valid = (s_pc.size() > 0) && gate;
    in_pc4   = (s_pc.size() > 0) ? s_pc[0] : 16'h0;
    in_instr = (s_in.size() > 0) ? s_in[0] : 16'h0;
    @(negedge clock);
    n    = q_pc.size();
    rdy  = (n < 2) && ifid_write;
    cons = (n > 0) && out_ready && ifid_write;
    acc  = in_valid && rdy;
    chk("out_valid", 32'(out_valid), int'(n > 0));
    chk("in_ready", 32'(in_ready), int'(rdy));
    chk("out_pc4", 32'(out_pc4), e_pc);
    chk("opcode", 32'(opcode), e_op);
    chk("instr_type", 32'(instr_type), e_ty);
    chk("rs", 32'(rs), e_rs);
    chk("rt", 32'(rt), e_rt);
    chk("rd", 32'(rd), e_rd);
    chk("funct", 32'(funct), e_fn);
    chk("imm", 32'(imm), e_imm);
    chk("jaddr", 32'(jaddr), e_ja);
    chk("stall_cnt", 32'(stall_cnt), e_cnt);
    chk("stall_cnt3", 32'(stall_cnt3), e_cnt3);
    chk("out_valid3", 32'(out_valid3), int'(n > 0));
    chk("in_ready3", 32'(in_ready3), int'(rdy));
    chk("out_pc4_3", 32'(out_pc43), e_pc);
    chk("jaddr3", 32'(jaddr3), e_ja);
    if (reset) begin
      q_pc.delete(); q_in.delete();
      clear_fields();
      e_cnt = 0; e_cnt3 = 0;
    end else begin
      stall = ((n > 0) && !out_ready) || !ifid_write;
      if (stall && e_cnt < 65535) e_cnt++;
      if (stall && e_cnt3 < 7) e_cnt3++;
      if (flush) begin
        q_pc.delete(); q_in.delete();
      end else begin
        chg = cons || (n == 0);
        if (cons) begin
          void'(q_pc.pop_front()); void'(q_in.pop_front());
        end
        if (acc) begin
          q_pc.push_back(in_pc4); q_in.push_back(in_instr);
        end
        if (chg && q_pc.size() > 0) set_fields(q_pc[0], q_in[0]);
      end
    end
    if (acc && !reset) begin
      void'(s_pc.pop_front()); void'(s_in.pop_front());
    end
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [15:0] pc, input logic [15:0] ins);
    s_pc.push_back(pc);
    s_in.push_back(ins);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_pc4 = '0; in_instr = '0;
    ifid_write = 1'b1; flush = 1'b0; out_ready = 1'b1;
    clear_fields(); e_cnt = 0; e_cnt3 = 0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    // decode of R, I and J formats
    push(16'h0002, 16'h1A5B);
    push(16'h0004, 16'h2C7F);
    push(16'h0006, 16'hF123);
    push(16'h0008, 16'h0FFF);
    push(16'h000A, 16'h8001);
    repeat (7) step();

    // backpressure: A main, B skid, C held by fetch
    out_ready = 1'b0;
    push(16'h00A0, 16'h1111);
    push(16'h00B0, 16'h7ABC);
    push(16'h00C0, 16'h9DEF);
    repeat (5) step();
    out_ready = 1'b1;
    repeat (5) step();

    // hazard freeze with a valid beat on the output
    out_ready = 1'b0;
    push(16'h0100, 16'h3210);
    repeat (2) step();
    out_ready = 1'b1;
    ifid_write = 1'b0;
    repeat (5) step();
    ifid_write = 1'b1;
    repeat (2) step();

    // flush in SKID with a new beat waiting
    out_ready = 1'b0;
    push(16'h0200, 16'h1234);
    push(16'h0202, 16'h5678);
    push(16'h0204, 16'hC00F);
    repeat (3) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    s_pc.delete(); s_in.delete();
    step();
    out_ready = 1'b1;
    repeat (2) step();

    // stall counter saturation, then reset mid-SKID
    out_ready = 1'b0;
    push(16'h0300, 16'h4321);
    push(16'h0302, 16'h1FFF);
    repeat (12) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    s_pc.delete(); s_in.delete();
    out_ready = 1'b1;
    repeat (2) step();

    // randomized traffic
    repeat (500) begin
      reset      = ($urandom_range(0, 99) == 0);
      flush      = ($urandom_range(0, 15) == 0);
      ifid_write = ($urandom_range(0, 7) != 0);
      out_ready  = ($urandom_range(0, 1) == 1);
      gate       = ($urandom_range(0, 3) != 0);
      if (s_pc.size() < 3 && $urandom_range(0, 1) == 1)
        push(16'($urandom), 16'($urandom));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ifid_stage_reg.md
Name: ifid_stage_reg

Overview:
- Parametrised IF/ID pipeline stage register for the 16-bit processor, sitting between the fetch stage and the decode stage.
- Accepts {PC+4, instruction} beats from fetch using a valid/ready handshake.
- Decodes each instruction into registered format fields on load.
- Holds beats in a one-entry skid buffer so fetch never loses a beat under decode backpressure.
- Supports hazard freeze (`ifid_write`), branch flush, and a saturating stall-cycle counter.

Parameters:
- PC_W, 16, width of PC+4 path.
- INSTR_W, 16, instruction width.
- OP_W, 4, opcode width; opcode = instr[INSTR_W-1 -: OP_W].
- REG_W, 3, register specifier width.
- FUNCT_W, 3, R-type funct width.
- IMM_W, 6, I-type immediate width.
- OP_RTYPE, 4'b0001, R-type opcode.
- OP_I_LO, 4'b0010, lowest I-type opcode (inclusive).
- OP_I_HI, 4'b0111, highest I-type opcode (inclusive).
- CNT_W, 16, stall counter width.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous active-high reset.
- in_valid  in  1  fetch beat present.
- in_ready  out  1  stage can accept a beat.
- in_pc4  in  PC_W  PC+4 of the fetched instruction.
- in_instr  in  INSTR_W  fetched instruction.
- ifid_write  in  1  0 = hazard freeze.
- flush  in  1  discard all held beats.
- out_valid  out  1  decoded beat present.
- out_ready  in  1  decode stage consumes the beat.
- out_pc4  out  PC_W  PC+4 of the output beat.
- opcode  out  OP_W  opcode field.
- instr_type  out  2  00 R, 01 I, 10 J.
- rs  out  REG_W  source register.
- rt  out  REG_W  second source register.
- rd  out  REG_W  destination register.
- funct  out  FUNCT_W  R-type function code.
- imm  out  IMM_W  I-type immediate.
- jaddr  out  INSTR_W-OP_W  J-type jump address.
- stall_cnt  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Storage:
  - main register feeds all outputs.
  - skid register holds one overflow beat.
  - Each register has its own valid bit.
- Handshake terms:
  - in_ready = !skid_valid & ifid_write (combinational).
  - accept = in_valid & in_ready.
  - consume = out_valid & out_ready & ifid_write.
  - out_valid = main_valid.
- State machine (derived from valid bits):
  - EMPTY (main 0, skid 0):
    - accept -> FULL, load main.
  - FULL (main 1, skid 0):
    - accept & consume -> FULL, main reloaded with the new beat.
    - accept & !consume -> SKID, new beat into skid.
    - !accept & consume -> EMPTY.
    - otherwise hold.
  - SKID (main 1, skid 1):
    - consume -> FULL, skid moves to main.
    - otherwise hold; in_ready = 0.
- Ordering: beats leave in arrival order. No beat is dropped or duplicated except by flush.
- Latency: accept in cycle N -> out_valid in cycle N+1 when the stage is EMPTY or consuming.
- Decode: computed from the instruction at the moment it is written into main (or into skid, then carried across). Fields are registered.
  - R-type (opcode == OP_RTYPE), instr_type 00:
    - rs = instr[11:9], rt = instr[8:6], rd = instr[5:3], funct = instr[2:0].
    - imm = 0, jaddr = 0.
  - I-type (OP_I_LO <= opcode <= OP_I_HI), instr_type 01:
    - rs = instr[11:9], rt = instr[8:6], imm = instr[5:0].
    - rd = 0, funct = 0, jaddr = 0.
  - All other opcodes (J-type, including 0000 and 1000-1111), instr_type 10:
    - jaddr = instr[11:0].
    - rs, rt, rd, funct, imm = 0.
  - Bit positions above are for the defaults and scale with the parameters: fields are packed MSB-first below the opcode.
- Freeze (ifid_write = 0):
  - No accept and no consume.
  - All registers, outputs and valid bits hold.
  - out_valid may remain 1, but decode must not treat the beat as consumed.
- Flush:
  - main_valid and skid_valid are cleared next cycle.
  - Field outputs hold their last values while out_valid = 0.
  - flush overrides ifid_write = 0.
  - An input beat presented in the flush cycle with in_ready = 1 counts as accepted and is discarded.
  - Flush has no effect on stall_cnt.
- stall_cnt:
  - Increments by 1 each cycle where (out_valid & !out_ready) | !ifid_write.
  - Saturates at 2^CNT_W - 1.
  - Cleared only by reset.
- Reset (synchronous, also when asserted mid-operation):
  - main_valid = 0, skid_valid = 0, stall_cnt = 0.
  - out_pc4, opcode, instr_type, rs, rt, rd, funct, imm, jaddr = 0.
  - in_ready = 1 in the first cycle after reset if ifid_write = 1.
  - Reset overrides flush and every handshake.

Test Plan:
- Reset then accept in_pc4 = 0x0002, in_instr = 0x1A5B with out_ready = 1 -> next cycle:
  - out_valid = 1, opcode = 1, instr_type = 00.
  - rs = 5, rt = 1, rd = 3, funct = 3, imm = 0, jaddr = 0.
- in_instr = 0x2C7F -> instr_type = 01, rs = 6, rt = 1, imm = 0x3F, rd = 0. in_instr = 0xF123 -> instr_type = 10, jaddr = 0x123, all other fields 0.
- Backpressure:
  - Stimulus: out_ready = 0; send beats A, B, C on consecutive cycles.
  - Response: A in main, B in skid, in_ready = 0 while C is held by fetch; release out_ready -> output order A, B, C with no loss or duplication.
- In SKID state, assert flush for one cycle with a new in_valid beat -> next cycle out_valid = 0, in_ready = 1, and the flushed and new beats never appear at the output.
- ifid_write = 0 for 5 cycles with out_valid = 1, out_ready = 1:
  - Outputs hold and in_ready = 0.
  - stall_cnt advances by 5.
  - Beat is consumed only after ifid_write returns to 1.
- CNT_W = 3, hold out_ready = 0 with out_valid = 1 for 10 cycles -> stall_cnt saturates at 7. Assert reset mid-SKID -> all outputs 0 the next cycle.
